// File: rtl/alarm_set_controller_if.sv
// Signal bundle between the alarm-set controller and its surroundings:
// button/tick/time inputs on one side, load strobe and display outputs on the other.
interface alarm_set_controller_if;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_inc;
    logic [15:0] cur_time;
    logic        load;
    logic [15:0] load_time;
    logic [15:0] disp_digits;
    logic [3:0]  digit_blank;
    logic        disp_alarm;
    logic        alarm_en;
    logic        alarm_ring;
    logic        edit_active;

    // Environment side: drives buttons, tick and running time; observes the controller.
    modport master (
        output tick_1hz, btn_mode, btn_inc, cur_time,
        input  load, load_time, disp_digits, digit_blank,
        input  disp_alarm, alarm_en, alarm_ring, edit_active
    );

    // Controller side.
    modport slave (
        input  tick_1hz, btn_mode, btn_inc, cur_time,
        output load, load_time, disp_digits, digit_blank,
        output disp_alarm, alarm_en, alarm_ring, edit_active
    );
endinterface

// File: rtl/alarm_set_controller.sv
// Mode/edit sequencer for the alarm clock: time-set and alarm-set editing with
// auto-repeat, blinking of the digits under edit, alarm match detection and ringer.
module alarm_set_controller #(
    parameter int BLINK_DIV    = 1250,
    parameter int REPEAT_DELAY = 2500,
    parameter int REPEAT_RATE  = 500,
    parameter int RING_SECONDS = 60
) (
    input  logic                  clk_in,
    input  logic                  reset,
    alarm_set_controller_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_AH = 3'd3,
        ST_SET_AM = 3'd4,
        ST_RING   = 3'd5
    } state_t;

    // First repeat fires once the level has been high for REPEAT_DELAY cycles,
    // counting the press cycle itself.
    localparam logic [31:0] RPT_FIRST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_RATE   = 32'(REPEAT_RATE);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
    localparam logic [31:0] RING_LAST  = 32'(RING_SECONDS - 1);

    // BCD hour increment, wrapping 23 -> 00.
    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        logic [7:0] r;
        if (h[7:4] >= 4'd2 && h[3:0] >= 4'd3) begin
            r = 8'h00;
        end else if (h[3:0] >= 4'd9) begin
            r = {h[7:4] + 4'd1, 4'd0};
        end else begin
            r = {h[7:4], h[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD minute increment, wrapping 59 -> 00 with no carry out.
    function automatic logic [7:0] minute_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m[3:0] >= 4'd9) begin
            if (m[7:4] >= 4'd5) begin
                r = 8'h00;
            end else begin
                r = {m[7:4] + 4'd1, 4'd0};
            end
        end else begin
            r = {m[7:4], m[3:0] + 4'd1};
        end
        return r;
    endfunction

    state_t      state_reg, state_next;
    logic [15:0] edit_reg, edit_next;
    logic [15:0] alarm_reg, alarm_next;
    logic        alarm_en_reg, alarm_en_next;
    logic [31:0] ring_cnt_reg, ring_cnt_next;

    logic        mode_prev_reg, inc_prev_reg;
    logic        match_reg, match_prev_reg;

    logic [31:0] rpt_cnt_reg, rpt_cnt_next;
    logic        rpt_armed_reg, rpt_armed_next;
    logic [31:0] blink_cnt_reg, blink_cnt_next;
    logic        blink_phase_reg, blink_phase_next;

    logic        load_reg, load_next;
    logic [15:0] load_time_reg;
    logic [15:0] disp_digits_reg, disp_next;
    logic [3:0]  digit_blank_reg, blank_next;
    logic        disp_alarm_reg, disp_alarm_next;
    logic        alarm_ring_reg;
    logic        edit_active_reg;

    logic mode_press, inc_press, inc_held, match_rise, in_set;
    logic rpt_due, inc_fire;
    logic hour_sel, min_sel;

    assign mode_press = bus.btn_mode & ~mode_prev_reg;
    assign inc_press  = bus.btn_inc & ~inc_prev_reg;
    assign inc_held   = bus.btn_inc & inc_prev_reg;
    assign match_rise = match_reg & ~match_prev_reg;
    assign in_set     = (state_reg == ST_SET_H)  || (state_reg == ST_SET_M) ||
                        (state_reg == ST_SET_AH) || (state_reg == ST_SET_AM);

    // A cleared repeat counter (zero) never fires; only a fresh press re-arms it.
    assign rpt_due  = (rpt_cnt_reg != 32'd0) &&
                      (rpt_armed_reg ? (rpt_cnt_reg >= RPT_RATE) : (rpt_cnt_reg >= RPT_FIRST));
    // Mode wins over inc whenever both are active in the same cycle.
    assign inc_fire = in_set && !mode_press && (inc_press || (inc_held && rpt_due));

    // Button history and registered alarm match.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            mode_prev_reg  <= 1'b0;
            inc_prev_reg   <= 1'b0;
            match_reg      <= 1'b0;
            match_prev_reg <= 1'b0;
        end else begin
            mode_prev_reg  <= bus.btn_mode;
            inc_prev_reg   <= bus.btn_inc;
            match_reg      <= alarm_en_reg && (bus.cur_time == alarm_reg);
            match_prev_reg <= match_reg;
        end
    end

    // Sequencer state and the edit/alarm registers it owns.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_RUN;
            edit_reg     <= 16'h0000;
            alarm_reg    <= 16'h0000;
            alarm_en_reg <= 1'b0;
            ring_cnt_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            edit_reg     <= edit_next;
            alarm_reg    <= alarm_next;
            alarm_en_reg <= alarm_en_next;
            ring_cnt_reg <= ring_cnt_next;
        end
    end

    // Next-state and edit actions for each mode.
    always_comb begin
        state_next    = state_reg;
        edit_next     = edit_reg;
        alarm_next    = alarm_reg;
        alarm_en_next = alarm_en_reg;
        ring_cnt_next = ring_cnt_reg;
        load_next     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                // An alarm hit takes the cycle; presses in that cycle are dropped.
                if (match_rise) begin
                    state_next    = ST_RING;
                    ring_cnt_next = 32'd0;
                end else if (mode_press) begin
                    state_next = ST_SET_H;
                    edit_next  = bus.cur_time;
                end else if (inc_press) begin
                    alarm_en_next = ~alarm_en_reg;
                end
            end
            ST_SET_H: begin
                if (mode_press) begin
                    state_next = ST_SET_M;
                end else if (inc_fire) begin
                    edit_next[15:8] = hour_inc(edit_reg[15:8]);
                end
            end
            ST_SET_M: begin
                if (mode_press) begin
                    state_next = ST_SET_AH;
                    load_next  = 1'b1;
                end else if (inc_fire) begin
                    edit_next[7:0] = minute_inc(edit_reg[7:0]);
                end
            end
            ST_SET_AH: begin
                if (mode_press) begin
                    state_next = ST_SET_AM;
                end else if (inc_fire) begin
                    alarm_next[15:8] = hour_inc(alarm_reg[15:8]);
                end
            end
            ST_SET_AM: begin
                if (mode_press) begin
                    state_next = ST_RUN;
                end else if (inc_fire) begin
                    alarm_next[7:0] = minute_inc(alarm_reg[7:0]);
                end
            end
            ST_RING: begin
                if (mode_press || inc_press) begin
                    state_next = ST_RUN;
                end else if (bus.tick_1hz) begin
                    if (ring_cnt_reg >= RING_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        ring_cnt_next = ring_cnt_reg + 32'd1;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Auto-repeat counter: cycles since the last increment while inc stays held.
    always_comb begin
        rpt_cnt_next   = 32'd0;
        rpt_armed_next = 1'b0;
        if (in_set && !mode_press && bus.btn_inc) begin
            if (inc_press) begin
                rpt_cnt_next = 32'd1;
            end else if (rpt_cnt_reg != 32'd0) begin
                if (rpt_due) begin
                    rpt_cnt_next   = 32'd1;
                    rpt_armed_next = 1'b1;
                end else begin
                    rpt_cnt_next   = rpt_cnt_reg + 32'd1;
                    rpt_armed_next = rpt_armed_reg;
                end
            end
        end
    end

    // Blink timebase; an increment restarts it so the edited digits show solid.
    always_comb begin
        blink_cnt_next   = blink_cnt_reg + 32'd1;
        blink_phase_next = blink_phase_reg;
        if (inc_fire) begin
            blink_cnt_next   = 32'd0;
            blink_phase_next = 1'b0;
        end else if (blink_cnt_reg >= BLINK_LAST) begin
            blink_cnt_next   = 32'd0;
            blink_phase_next = ~blink_phase_reg;
        end
    end

    // Repeat and blink counter registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rpt_cnt_reg     <= 32'd0;
            rpt_armed_reg   <= 1'b0;
            blink_cnt_reg   <= 32'd0;
            blink_phase_reg <= 1'b0;
        end else begin
            rpt_cnt_reg     <= rpt_cnt_next;
            rpt_armed_reg   <= rpt_armed_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    // Display source selection, looking at where the sequencer is going next.
    always_comb begin
        disp_next       = bus.cur_time;
        disp_alarm_next = 1'b0;
        case (state_next)
            ST_SET_H, ST_SET_M: begin
                disp_next = edit_next;
            end
            ST_SET_AH, ST_SET_AM: begin
                disp_next       = alarm_next;
                disp_alarm_next = 1'b1;
            end
            default: begin
                disp_next = bus.cur_time;
            end
        endcase
    end

    assign hour_sel = (state_next == ST_SET_H) || (state_next == ST_SET_AH);
    assign min_sel  = (state_next == ST_SET_M) || (state_next == ST_SET_AM);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
            if (gi >= 2) begin : g_hour
                assign blank_next[gi] = blink_phase_next & hour_sel;
            end else begin : g_min
                assign blank_next[gi] = blink_phase_next & min_sel;
            end
        end
    endgenerate

    // Registered outputs; load_time keeps the last loaded value after the strobe.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            load_reg        <= 1'b0;
            load_time_reg   <= 16'h0000;
            disp_digits_reg <= 16'h0000;
            digit_blank_reg <= 4'b0000;
            disp_alarm_reg  <= 1'b0;
            alarm_ring_reg  <= 1'b0;
            edit_active_reg <= 1'b0;
        end else begin
            load_reg <= load_next;
            if (load_next) begin
                load_time_reg <= edit_reg;
            end
            disp_digits_reg <= disp_next;
            digit_blank_reg <= blank_next;
            disp_alarm_reg  <= disp_alarm_next;
            alarm_ring_reg  <= (state_next == ST_RING);
            edit_active_reg <= (state_next == ST_SET_H)  || (state_next == ST_SET_M) ||
                               (state_next == ST_SET_AH) || (state_next == ST_SET_AM);
        end
    end

    assign bus.load        = load_reg;
    assign bus.load_time   = load_time_reg;
    assign bus.disp_digits = disp_digits_reg;
    assign bus.digit_blank = digit_blank_reg;
    assign bus.disp_alarm  = disp_alarm_reg;
    assign bus.alarm_en    = alarm_en_reg;
    assign bus.alarm_ring  = alarm_ring_reg;
    assign bus.edit_active = edit_active_reg;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Bench for alarm_set_controller: directed scenarios plus random button/time
// traffic, every cycle compared against a time-of-day level reference model.
module tb_alarm_set_controller;

    localparam int BLINK_DIV    = 8;
    localparam int REPEAT_DELAY = 10;
    localparam int REPEAT_RATE  = 4;
    localparam int RING_SECONDS = 3;

    localparam int M_RUN = 0, M_SH = 1, M_SM = 2, M_SAH = 3, M_SAM = 4, M_RING = 5;

    logic clk_in;
    logic reset;
    alarm_set_controller_if ifc ();

    alarm_set_controller #(
        .BLINK_DIV   (BLINK_DIV),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE),
        .RING_SECONDS(RING_SECONDS)
    ) u_dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (ifc)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: times kept as integer hours/minutes.
    int          m_mode, m_eh, m_em, m_ah, m_am, m_hold, m_blink_t, m_ticks;
    bit          m_en, m_pm, m_pi, m_h1, m_h2;
    bit          x_load;
    logic [15:0] x_lt, x_disp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic m_reset();
        m_mode = M_RUN; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
        m_hold = -1; m_blink_t = 0; m_ticks = 0;
        m_en = 0; m_pm = 0; m_pi = 0; m_h1 = 0; m_h2 = 0;
        x_load = 0; x_lt = 16'h0; x_disp = 16'h0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic m_step();
        bit mp, ip, rise, cond, fire, in_set;
        int nm;
        mp     = ifc.btn_mode && !m_pm;
        ip     = ifc.btn_inc && !m_pi;
        rise   = m_h1 && !m_h2;
        cond   = m_en && (ifc.cur_time == bcd(m_ah, m_am));
        in_set = (m_mode >= M_SH) && (m_mode <= M_SAM);
        fire   = 0;
        x_load = 0;
        nm     = m_mode;
        if (in_set && !mp && ifc.btn_inc) begin
            if (ip) begin
                m_hold = 0;
                fire   = 1;
            end else if (m_hold >= 0) begin
                m_hold++;
                fire = (m_hold >= REPEAT_DELAY - 1) &&
                       (((m_hold - (REPEAT_DELAY - 1)) % REPEAT_RATE) == 0);
            end
        end else begin
            m_hold = -1;
        end
        case (m_mode)
            M_RUN: begin
                if (rise) begin
                    nm = M_RING; m_ticks = 0;
                end else if (mp) begin
                    nm   = M_SH;
                    m_eh = int'(ifc.cur_time[15:12]) * 10 + int'(ifc.cur_time[11:8]);
                    m_em = int'(ifc.cur_time[7:4]) * 10 + int'(ifc.cur_time[3:0]);
                end else if (ip) begin
                    m_en = !m_en;
                end
            end
            M_SH:  if (mp) nm = M_SM;  else if (fire) m_eh = (m_eh + 1) % 24;
            M_SM:  if (mp) begin nm = M_SAH; x_load = 1; x_lt = bcd(m_eh, m_em); end
                   else if (fire) m_em = (m_em + 1) % 60;
            M_SAH: if (mp) nm = M_SAM; else if (fire) m_ah = (m_ah + 1) % 24;
            M_SAM: if (mp) nm = M_RUN; else if (fire) m_am = (m_am + 1) % 60;
            default: begin
                if (mp || ip) nm = M_RUN;
                else if (ifc.tick_1hz) begin
                    m_ticks++;
                    if (m_ticks >= RING_SECONDS) nm = M_RUN;
                end
            end
        endcase
        m_blink_t = fire ? 0 : m_blink_t + 1;
        m_h2   = m_h1;
        m_h1   = cond;
        m_pm   = ifc.btn_mode;
        m_pi   = ifc.btn_inc;
        m_mode = nm;
        if (m_mode == M_SH || m_mode == M_SM)        x_disp = bcd(m_eh, m_em);
        else if (m_mode == M_SAH || m_mode == M_SAM) x_disp = bcd(m_ah, m_am);
        else                                          x_disp = ifc.cur_time;
    endtask

    task automatic check_all();
        bit   ph;
        logic [3:0] xb;
        ph = ((m_blink_t / BLINK_DIV) % 2) == 1;
        xb = 4'b0000;
        if (m_mode == M_SH || m_mode == M_SAH) xb = {ph, ph, 2'b00};
        if (m_mode == M_SM || m_mode == M_SAM) xb = {2'b00, ph, ph};
        chk("load",        32'(ifc.load),        32'(x_load));
        chk("load_time",   32'(ifc.load_time),   32'(x_lt));
        chk("disp_digits", 32'(ifc.disp_digits), 32'(x_disp));
        chk("digit_blank", 32'(ifc.digit_blank), 32'(xb));
        chk("disp_alarm",  32'(ifc.disp_alarm),  32'(m_mode == M_SAH || m_mode == M_SAM));
        chk("alarm_en",    32'(ifc.alarm_en),    32'(m_en));
        chk("alarm_ring",  32'(ifc.alarm_ring),  32'(m_mode == M_RING));
        chk("edit_active", 32'(ifc.edit_active), 32'(m_mode >= M_SH && m_mode <= M_SAM));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_load"},   32'(ifc.load),        32'd0);
        chk({tag, "_ltime"},  32'(ifc.load_time),   32'd0);
        chk({tag, "_disp"},   32'(ifc.disp_digits), 32'd0);
        chk({tag, "_blank"},  32'(ifc.digit_blank), 32'd0);
        chk({tag, "_dalarm"}, 32'(ifc.disp_alarm),  32'd0);
        chk({tag, "_en"},     32'(ifc.alarm_en),    32'd0);
        chk({tag, "_ring"},   32'(ifc.alarm_ring),  32'd0);
        chk({tag, "_edit"},   32'(ifc.edit_active), 32'd0);
    endtask

    task automatic cyc(input bit t, input bit bm, input bit bi);
        ifc.tick_1hz = t;
        ifc.btn_mode = bm;
        ifc.btn_inc  = bi;
        @(posedge clk_in);
        #1;
        m_step();
        check_all();
    endtask

    task automatic press_mode();
        cyc(0, 1, 0);
        $display("press mode : disp=%h edit=%0d alarm_disp=%0d load=%0d", ifc.disp_digits,
                 ifc.edit_active, ifc.disp_alarm, ifc.load);
        cyc(0, 0, 0);
    endtask

    task automatic press_inc();
        cyc(0, 0, 1);
        $display("press inc  : disp=%h blank=%b en=%0d ring=%0d", ifc.disp_digits,
                 ifc.digit_blank, ifc.alarm_en, ifc.alarm_ring);
        cyc(0, 0, 0);
    endtask

    // Walk the remaining SET states back to RUN starting from SET_H.
    task automatic exit_from_set_h();
        repeat (4) press_mode();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int saw_on, saw_off;

        // Reset with buttons wiggling
        reset = 1'b0;
        ifc.tick_1hz = 0; ifc.btn_mode = 0; ifc.btn_inc = 0; ifc.cur_time = 16'h0859;
        m_reset();
        @(posedge clk_in); #1;
        ifc.btn_mode = 1; ifc.btn_inc = 1;
        @(posedge clk_in); #1;
        check_zero("rst");
        ifc.btn_mode = 0; ifc.btn_inc = 0;
        @(posedge clk_in); #1;
        reset = 1'b1;
        repeat (3) cyc(0, 0, 0);
        chk("after_rst_edit", 32'(ifc.edit_active), 32'd0);
        $display("reset released: disp=%h en=%0d", ifc.disp_digits, ifc.alarm_en);

        // Time set 08:59 -> 23:01
        press_mode();
        repeat (15) press_inc();
        press_mode();
        repeat (2) press_inc();
        cyc(0, 1, 0);
        chk("load_pulse", 32'(ifc.load), 32'd1);
        chk("load_value", 32'(ifc.load_time), 32'h2301);
        chk("in_set_ah",  32'(ifc.disp_alarm), 32'd1);
        cyc(0, 0, 0);
        chk("load_single", 32'(ifc.load), 32'd0);
        chk("load_hold",   32'(ifc.load_time), 32'h2301);
        press_mode();
        press_mode();

        // Wrap boundaries
        ifc.cur_time = 16'h2359;
        press_mode();
        press_inc();
        chk("hour_23_00", 32'(ifc.disp_digits), 32'h0059);
        press_mode();
        press_inc();
        chk("min_59_00", 32'(ifc.disp_digits), 32'h0000);
        repeat (3) press_mode();
        ifc.cur_time = 16'h0919;
        press_mode();
        press_inc();
        chk("hour_09_10", 32'(ifc.disp_digits), 32'h1019);
        press_mode();
        press_inc();
        chk("min_19_20", 32'(ifc.disp_digits), 32'h1020);
        repeat (3) press_mode();
        ifc.cur_time = 16'h1959;
        press_mode();
        press_inc();
        chk("hour_19_20", 32'(ifc.disp_digits), 32'h2059);
        exit_from_set_h();

        // Auto-repeat: 30 held cycles -> 7 increments
        ifc.cur_time = 16'h1200;
        press_mode();
        press_mode();
        repeat (30) cyc(0, 0, 1);
        cyc(0, 0, 0);
        $display("repeat hold: disp=%h", ifc.disp_digits);
        chk("repeat_7", 32'(ifc.disp_digits), 32'h1207);
        cyc(0, 1, 1);
        chk("mode_wins_load", 32'(ifc.load_time), 32'h1207);
        chk("mode_wins_state", 32'(ifc.disp_alarm), 32'd1);
        cyc(0, 0, 0);

        // Alarm 07:00, arm, ring, cancel by press
        repeat (7) press_inc();
        press_mode();
        press_mode();
        press_inc();
        chk("armed", 32'(ifc.alarm_en), 32'd1);
        ifc.cur_time = 16'h0659;
        repeat (3) cyc(0, 0, 0);
        ifc.cur_time = 16'h0700;
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            cyc(0, 0, 0);
            got = ifc.alarm_ring;
        end
        chk("ring_start", 32'(got), 32'd1);
        cyc(0, 0, 1);
        chk("ring_cancel", 32'(ifc.alarm_ring), 32'd0);
        chk("en_kept", 32'(ifc.alarm_en), 32'd1);
        cyc(0, 0, 0);
        repeat (5) cyc(0, 0, 0);
        chk("no_retrigger", 32'(ifc.alarm_ring), 32'd0);

        // Ring self-cancel after RING_SECONDS ticks
        ifc.cur_time = 16'h0701;
        repeat (3) cyc(0, 0, 0);
        ifc.cur_time = 16'h0700;
        repeat (3) cyc(0, 0, 0);
        chk("ring_again", 32'(ifc.alarm_ring), 32'd1);
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0);
        chk("ring_2ticks", 32'(ifc.alarm_ring), 32'd1);
        cyc(1, 0, 0);
        chk("ring_3ticks", 32'(ifc.alarm_ring), 32'd0);
        $display("ring timeout: ring=%0d en=%0d", ifc.alarm_ring, ifc.alarm_en);

        // Blink in SET_H, match during SET ignored
        ifc.cur_time = 16'h0100;
        repeat (2) cyc(0, 0, 0);
        press_mode();
        saw_on = 0; saw_off = 0;
        for (int k = 0; k < 3 * BLINK_DIV; k++) begin
            cyc(0, 0, 0);
            if (ifc.digit_blank == 4'b1100) saw_on++;
            if (ifc.digit_blank == 4'b0000) saw_off++;
        end
        chk("blink_on_seen",  32'(saw_on > 0),  32'd1);
        chk("blink_off_seen", 32'(saw_off > 0), 32'd1);
        cyc(0, 0, 1);
        chk("blink_inc_zero", 32'(ifc.digit_blank), 32'd0);
        cyc(0, 0, 0);
        ifc.cur_time = 16'h0659;
        cyc(0, 0, 0);
        ifc.cur_time = 16'h0700;
        repeat (4) cyc(0, 0, 0);
        chk("set_no_ring", 32'(ifc.alarm_ring), 32'd0);
        exit_from_set_h();
        repeat (3) cyc(0, 0, 0);
        chk("late_no_ring", 32'(ifc.alarm_ring), 32'd0);

        // Reset mid-edit in SET_M
        ifc.cur_time = 16'h1234;
        press_mode();
        press_mode();
        chk("edit_1234", 32'(ifc.disp_digits), 32'h1234);
        reset = 1'b0;
        #1;
        check_zero("midrst");
        m_reset();
        @(posedge clk_in); #1;
        chk("midrst_load", 32'(ifc.load), 32'd0);
        reset = 1'b1;
        cyc(0, 0, 0);
        chk("midrst_disp", 32'(ifc.disp_digits), 32'h1234);
        chk("midrst_run",  32'(ifc.edit_active), 32'd0);
        $display("mid-edit reset: disp=%h edit=%0d", ifc.disp_digits, ifc.edit_active);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit t, bm, bi;
            bm = ifc.btn_mode;
            bi = ifc.btn_inc;
            if ($urandom_range(0, 7) == 0) bm = !bm;
            if ($urandom_range(0, 5) == 0) bi = !bi;
            t = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    ifc.cur_time = bcd(m_ah, m_am);
                else
                    ifc.cur_time = bcd(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
            end
            cyc(t, bm, bi);
            if (n % 500 == 499)
                $display("random cycle %0d: disp=%h en=%0d ring=%0d", n + 1,
                         ifc.disp_digits, ifc.alarm_en, ifc.alarm_ring);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_set_controller.md
Name: alarm_set_controller

Overview:
- Mode/edit sequencer for the alarm clock.
- Turns the mode and increment buttons into time-set and alarm-set operations.
- Loads new BCD time into the hour/minute counter chain, owns the alarm time register and alarm-enable flag, and detects the alarm match to drive the ringer.
- Feeds the seven-segment mux with display digits and a blink mask.
- Sits between the debounced button inputs, the time counters and segment7, in the pll_clk domain.

Parameters:
- BLINK_DIV, 1250: clk_in cycles per blink-phase toggle.
- REPEAT_DELAY, 2500: cycles btn_inc must be held after a press before auto-repeat starts.
- REPEAT_RATE, 500: cycles between auto-repeat increments.
- RING_SECONDS, 60: tick_1hz pulses before the ringer self-cancels.

Ports:
- clk_in  in  1  system clock (PLL output)
- reset  in  1  asynchronous, active-low; 0 = reset
- tick_1hz  in  1  one-cycle pulse per second
- btn_mode  in  1  debounced, synchronized level, 1 = pressed
- btn_inc  in  1  debounced, synchronized level, 1 = pressed
- cur_time  in  16  running time BCD {hh,hl,mh,ml}; hh upper 2 bits are 0
- load  out  1  one-cycle strobe: counters take load_time and clear seconds
- load_time  out  16  BCD {hh,hl,mh,ml} to load; valid while load=1
- disp_digits  out  16  BCD digits to segment7
- digit_blank  out  4  1 = blank that digit; [3:2] hours, [1:0] minutes
- disp_alarm  out  1  1 while the alarm time is shown
- alarm_en  out  1  alarm armed
- alarm_ring  out  1  ringer drive
- edit_active  out  1  1 in any SET state

Behaviour:
- Reset (async assert, sync release): state RUN, all outputs 0, edit time 00:00, alarm time 00:00, button history 0, blink phase 0. A reset mid-edit discards the edit and never pulses load.
- Press = rising edge of the button level (registered previous value).
- If btn_mode and btn_inc are pressed in the same cycle, mode wins and inc is ignored.
- States: RUN, SET_H, SET_M, SET_AH, SET_AM, RING.
- RUN:
  - mode press -> SET_H, edit <= cur_time.
  - inc press toggles alarm_en.
- SET_H: inc increments edit hour mod 24 in BCD: 09->10, 19->20, 23->00. mode -> SET_M.
- SET_M:
  - inc increments edit minute mod 60: x9->(x+1)0, 59->00, no carry into hour.
  - mode -> SET_AH. In the transition cycle: load=1 for exactly one cycle and load_time = edit value.
- SET_AH / SET_AM: same increment rules applied directly to the alarm register. mode: SET_AH -> SET_AM -> RUN.
- Auto-repeat (SET states only):
  - A press increments immediately.
  - While the level stays high, first repeat after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
  - Release or a state change clears the repeat counter.
- Blink:
  - Free-running counter toggles the phase every BLINK_DIV cycles.
  - SET_H/SET_AH: digit_blank[3:2] = phase; SET_M/SET_AM: digit_blank[1:0] = phase; all others 0.
  - Any increment forces phase 0 and restarts the counter.
- Display:
  - RUN/RING: disp_digits = cur_time.
  - SET_H/SET_M: edit value.
  - SET_AH/SET_AM: alarm value, disp_alarm=1.
  - edit_active=1 in the four SET states.
- Alarm:
  - match = alarm_en && cur_time == alarm time, registered.
  - Its rising edge while in RUN -> RING.
  - A rising edge in any other state is ignored, with no retrigger later in the same minute.
- RING:
  - alarm_ring=1.
  - Any press (mode or inc) -> RUN without changing alarm_en or alarm_time.
  - After RING_SECONDS tick_1hz pulses -> RUN.
  - alarm_ring drops in the same cycle the state leaves RING.
- Outputs are registered; load_time holds its value after the strobe.

Test Plan:
- Reset then release; toggle buttons -> state RUN, load=0, alarm_en=0. Assert reset in SET_M with edit 12:34 -> RUN, no load pulse, disp_digits=cur_time.
- cur_time=08:59; mode, inc x15 in SET_H, mode, inc x2, mode -> edit 23:01; single load pulse with load_time=0x2301; state SET_AH.
- SET_H with edit 23 -> one inc gives 00. SET_M with 59 -> 00 and hour unchanged. SET_H 09 -> 10, 19 -> 20.
- With REPEAT_DELAY=10 and REPEAT_RATE=4, hold inc 30 cycles in SET_M from 00 -> 1+1+5 = 07 increments, minute = 07. Same-cycle mode+inc -> state advances, no increment.
- Set alarm 07:00, alarm_en=1. Drive cur_time 06:59 -> 07:00 -> RING, alarm_ring=1. inc press -> RUN, ring=0, alarm_en stays 1. Repeat with no press, RING_SECONDS=3 -> ring drops after the 3rd tick.
- In SET_H, digit_blank toggles 4'b1100/4'b0000 every BLINK_DIV cycles. An inc forces 4'b0000. A match while in SET states gives no RING.
